// File: rtl/net_egr_protocol_corrector.sv
// -----------------------------------------------------------------------------
// net_egr_protocol_corrector
//
// Egress AXI-Stream protocol corrector placed between the user application's
// egress output and the network decoupler's egress input. Every beat passes
// through a single register slice. Packets that run past MAX_PKT_BEATS are
// truncated with a generated tlast, packets that stall mid-flight for
// TIMEOUT_CYCLES are closed with a synthetic empty tlast beat, and tid/tdest
// are pinned to the values seen on the first beat of each packet. After a
// forced termination, the remainder of the offending packet is swallowed.
//
// Ports:
//   aclk, aresetn          clock, synchronous active-low reset
//   axis_in_*              egress stream from the application (tready out)
//   axis_out_*             corrected stream to the decoupler (tready in)
//   axis_egr_tlast_forced  high with any output beat whose tlast was made here
//   pkt_in_progress        a packet is open (state is not IDLE)
//   err_oversize           sticky: packet truncated at MAX_PKT_BEATS
//   err_timeout            sticky: timeout beat injected
//   err_id_change          sticky: tid/tdest changed mid-packet
//   err_clear              synchronous clear of the sticky error bits
// -----------------------------------------------------------------------------
module net_egr_protocol_corrector #(
    parameter int AXIS_BUS_WIDTH  = 64,
    parameter int AXIS_ID_WIDTH   = 4,
    parameter int AXIS_DEST_WIDTH = 4,
    parameter int MAX_PKT_BEATS   = 190,
    parameter int TIMEOUT_CYCLES  = 1024,
    localparam int ID_W   = (AXIS_ID_WIDTH > 0) ? AXIS_ID_WIDTH : 1,
    localparam int DEST_W = (AXIS_DEST_WIDTH > 0) ? AXIS_DEST_WIDTH : 1,
    localparam int KEEP_W = AXIS_BUS_WIDTH / 8
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [AXIS_BUS_WIDTH-1:0] axis_in_tdata,
    input  logic [ID_W-1:0]           axis_in_tid,
    input  logic [DEST_W-1:0]         axis_in_tdest,
    input  logic [KEEP_W-1:0]         axis_in_tkeep,
    input  logic                      axis_in_tlast,
    input  logic                      axis_in_tvalid,
    output logic                      axis_in_tready,
    output logic [AXIS_BUS_WIDTH-1:0] axis_out_tdata,
    output logic [ID_W-1:0]           axis_out_tid,
    output logic [DEST_W-1:0]         axis_out_tdest,
    output logic [KEEP_W-1:0]         axis_out_tkeep,
    output logic                      axis_out_tlast,
    output logic                      axis_out_tvalid,
    input  logic                      axis_out_tready,
    output logic                      axis_egr_tlast_forced,
    output logic                      pkt_in_progress,
    output logic                      err_oversize,
    output logic                      err_timeout,
    output logic                      err_id_change,
    input  logic                      err_clear
);

    localparam int BEAT_W = $clog2(MAX_PKT_BEATS + 1);
    localparam int TO_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    // A zero-width id/dest is carried as a 1-bit dummy port; mask it out of
    // the stability check so an undriven dummy cannot raise err_id_change.
    localparam logic [ID_W-1:0]   ID_MASK   = (AXIS_ID_WIDTH > 0)   ? {ID_W{1'b1}}   : {ID_W{1'b0}};
    localparam logic [DEST_W-1:0] DEST_MASK = (AXIS_DEST_WIDTH > 0) ? {DEST_W{1'b1}} : {DEST_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IN_PKT = 2'd1,
        ST_INJECT = 2'd2,
        ST_DROP   = 2'd3
    } state_t;

    state_t                    state_r, state_s;
    logic [BEAT_W-1:0]         beat_cnt_r, beat_cnt_s;
    logic [TO_W-1:0]           to_cnt_r, to_cnt_s;
    logic [ID_W-1:0]           lat_tid_r, lat_tid_s;
    logic [DEST_W-1:0]         lat_tdest_r, lat_tdest_s;

    logic [AXIS_BUS_WIDTH-1:0] out_tdata_r, ld_tdata_s;
    logic [ID_W-1:0]           out_tid_r, ld_tid_s;
    logic [DEST_W-1:0]         out_tdest_r, ld_tdest_s;
    logic [KEEP_W-1:0]         out_tkeep_r, ld_tkeep_s;
    logic                      out_tlast_r, ld_tlast_s;
    logic                      out_forced_r, ld_forced_s;
    logic                      out_tvalid_r;
    logic                      load_s;

    logic                      slot_free_s;
    logic                      in_tready_s;
    logic                      in_hs_s;
    logic                      id_mismatch_s;
    logic                      set_ov_s, set_to_s, set_id_s;
    logic                      err_ov_r, err_to_r, err_id_r;

    assign slot_free_s   = !out_tvalid_r || axis_out_tready;
    assign in_hs_s       = axis_in_tvalid && in_tready_s;
    assign id_mismatch_s = (|((axis_in_tid ^ lat_tid_r) & ID_MASK)) ||
                           (|((axis_in_tdest ^ lat_tdest_r) & DEST_MASK));

    // Input ready per state: follow the slice while forwarding, block while a
    // synthetic beat is pending, always accept while discarding.
    always_comb begin
        in_tready_s = 1'b0;
        case (state_r)
            ST_IDLE:   in_tready_s = slot_free_s;
            ST_IN_PKT: in_tready_s = slot_free_s;
            ST_INJECT: in_tready_s = 1'b0;
            ST_DROP:   in_tready_s = 1'b1;
            default:   in_tready_s = 1'b0;
        endcase
    end

    // Next-state, slice load values, counters and error set pulses.
    always_comb begin
        state_s     = state_r;
        beat_cnt_s  = beat_cnt_r;
        to_cnt_s    = to_cnt_r;
        lat_tid_s   = lat_tid_r;
        lat_tdest_s = lat_tdest_r;
        load_s      = 1'b0;
        ld_tdata_s  = axis_in_tdata;
        ld_tid_s    = lat_tid_r;
        ld_tdest_s  = lat_tdest_r;
        ld_tkeep_s  = axis_in_tkeep;
        ld_tlast_s  = axis_in_tlast;
        ld_forced_s = 1'b0;
        set_ov_s    = 1'b0;
        set_to_s    = 1'b0;
        set_id_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (in_hs_s) begin
                    load_s      = 1'b1;
                    ld_tid_s    = axis_in_tid;
                    ld_tdest_s  = axis_in_tdest;
                    lat_tid_s   = axis_in_tid;
                    lat_tdest_s = axis_in_tdest;
                    beat_cnt_s  = BEAT_W'(1);
                    to_cnt_s    = TO_W'(0);
                    if (axis_in_tlast) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_IN_PKT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_IN_PKT: begin
                if (in_hs_s) begin
                    load_s     = 1'b1;
                    beat_cnt_s = beat_cnt_r + BEAT_W'(1);
                    to_cnt_s   = TO_W'(0);
                    set_id_s   = id_mismatch_s;
                    if (axis_in_tlast) begin
                        state_s = ST_IDLE;
                    end else if (beat_cnt_r + BEAT_W'(1) == BEAT_W'(MAX_PKT_BEATS)) begin
                        // Last permitted beat without tlast: close it here.
                        ld_tlast_s  = 1'b1;
                        ld_forced_s = 1'b1;
                        set_ov_s    = 1'b1;
                        state_s     = ST_DROP;
                    end else begin
                        state_s = ST_IN_PKT;
                    end
                end else if (TIMEOUT_CYCLES > 0) begin
                    if (to_cnt_r + TO_W'(1) == TO_W'(TIMEOUT_CYCLES)) begin
                        to_cnt_s = TO_W'(0);
                        set_to_s = 1'b1;
                        state_s  = ST_INJECT;
                    end else begin
                        to_cnt_s = to_cnt_r + TO_W'(1);
                    end
                end else begin
                    to_cnt_s = TO_W'(0);
                end
            end

            ST_INJECT: begin
                if (slot_free_s) begin
                    load_s      = 1'b1;
                    ld_tdata_s  = {AXIS_BUS_WIDTH{1'b0}};
                    ld_tkeep_s  = {KEEP_W{1'b0}};
                    ld_tlast_s  = 1'b1;
                    ld_forced_s = 1'b1;
                    state_s     = ST_DROP;
                end else begin
                    state_s = ST_INJECT;
                end
            end

            ST_DROP: begin
                if (in_hs_s && axis_in_tlast) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DROP;
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Control state: FSM, counters and latched packet identity.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_r     <= ST_IDLE;
            beat_cnt_r  <= BEAT_W'(0);
            to_cnt_r    <= TO_W'(0);
            lat_tid_r   <= {ID_W{1'b0}};
            lat_tdest_r <= {DEST_W{1'b0}};
        end else begin
            state_r     <= state_s;
            beat_cnt_r  <= beat_cnt_s;
            to_cnt_r    <= to_cnt_s;
            lat_tid_r   <= lat_tid_s;
            lat_tdest_r <= lat_tdest_s;
        end
    end

    // Output slice: load when the slot is free, otherwise hold until taken.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            out_tvalid_r <= 1'b0;
            out_forced_r <= 1'b0;
            out_tdata_r  <= {AXIS_BUS_WIDTH{1'b0}};
            out_tid_r    <= {ID_W{1'b0}};
            out_tdest_r  <= {DEST_W{1'b0}};
            out_tkeep_r  <= {KEEP_W{1'b0}};
            out_tlast_r  <= 1'b0;
        end else if (load_s) begin
            out_tvalid_r <= 1'b1;
            out_forced_r <= ld_forced_s;
            out_tdata_r  <= ld_tdata_s;
            out_tid_r    <= ld_tid_s;
            out_tdest_r  <= ld_tdest_s;
            out_tkeep_r  <= ld_tkeep_s;
            out_tlast_r  <= ld_tlast_s;
        end else if (axis_out_tready) begin
            out_tvalid_r <= 1'b0;
            out_forced_r <= 1'b0;
        end else begin
            out_tvalid_r <= out_tvalid_r;
            out_forced_r <= out_forced_r;
        end
    end

    // Sticky errors: a set in the same cycle as err_clear wins.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            err_ov_r <= 1'b0;
            err_to_r <= 1'b0;
            err_id_r <= 1'b0;
        end else begin
            err_ov_r <= set_ov_s | (err_ov_r & ~err_clear);
            err_to_r <= set_to_s | (err_to_r & ~err_clear);
            err_id_r <= set_id_s | (err_id_r & ~err_clear);
        end
    end

    assign axis_in_tready        = in_tready_s;
    assign axis_out_tdata        = out_tdata_r;
    assign axis_out_tid          = out_tid_r;
    assign axis_out_tdest        = out_tdest_r;
    assign axis_out_tkeep        = out_tkeep_r;
    assign axis_out_tlast        = out_tlast_r;
    assign axis_out_tvalid       = out_tvalid_r;
    assign axis_egr_tlast_forced = out_forced_r;
    assign pkt_in_progress       = (state_r != ST_IDLE);
    assign err_oversize          = err_ov_r;
    assign err_timeout           = err_to_r;
    assign err_id_change         = err_id_r;

endmodule

// File: doc/net_egr_protocol_corrector.md
Name: net_egr_protocol_corrector

Overview:
- Egress AXI-Stream protocol corrector between the user application's egress output and the network decoupler's egress input.
- Registers every beat through a single-stage slice.
- Enforces a maximum packet length, an inter-beat timeout, and per-packet tid/tdest stability.
- Drives `axis_egr_tlast_forced` so the downstream decoupler sees a terminated packet even when the application misbehaves.

Parameters:
- AXIS_BUS_WIDTH, 64, tdata width in bits (multiple of 8).
- AXIS_ID_WIDTH, 4, tid width; port width is 1 when set to 0.
- AXIS_DEST_WIDTH, 4, tdest width; port width is 1 when set to 0.
- MAX_PKT_BEATS, 190, maximum beats per packet (minimum 2).
- TIMEOUT_CYCLES, 1024, maximum consecutive mid-packet cycles without an input handshake; 0 disables the timeout.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset
- axis_in_tdata/tid/tdest/tkeep/tlast/tvalid  in  AXIS_BUS_WIDTH/ID/DEST/BUS_WIDTH/8/1/1  egress stream from the application
- axis_in_tready  out  1  ready to the application
- axis_out_tdata/tid/tdest/tkeep/tlast/tvalid  out  same widths  corrected stream to the decoupler
- axis_out_tready  in  1  ready from the decoupler
- axis_egr_tlast_forced  out  1  high with any output beat whose tlast was generated here
- pkt_in_progress  out  1  state is not IDLE
- err_oversize  out  1  sticky: packet truncated at MAX_PKT_BEATS
- err_timeout  out  1  sticky: timeout beat injected
- err_id_change  out  1  sticky: tid/tdest changed mid-packet
- err_clear  in  1  synchronous clear of the sticky errors

Behaviour:
- Reset: aresetn, synchronous, active-low; clock aclk. Reset gives state=IDLE, out_tvalid=0, tlast_forced=0, all err_*=0, beat and timeout counters=0. Reset mid-packet discards the held beat and the partial packet.
- Output slice: one register; latency 1 cycle; full throughput.
  - Slot free = !out_tvalid || out_tready.
  - out_tvalid, data and sidebands hold stable until the output handshake.
  - tlast_forced is registered with its beat.
- axis_in_tready:
  - IDLE/IN_PKT: slot free.
  - INJECT: 0.
  - DROP: 1 (beats are discarded and never loaded).
- State IDLE:
  - Input handshake latches tid/tdest and loads the beat; beat count becomes 1.
  - tlast=1 stays in IDLE; otherwise go to IN_PKT.
- State IN_PKT:
  - Each accepted beat increments the beat count.
  - tid/tdest are replaced by the latched values. A mismatch sets err_id_change; the beat is still forwarded.
  - Input tlast returns to IDLE with no error.
  - If the beat is number MAX_PKT_BEATS and input tlast=0: output tlast=1, tlast_forced=1, set err_oversize, go to DROP.
  - A packet of exactly MAX_PKT_BEATS beats ending in tlast is legal.
- Timeout (IN_PKT only, TIMEOUT_CYCLES>0):
  - The counter increments each cycle with no input handshake and clears on a handshake.
  - On the cycle it would reach TIMEOUT_CYCLES (and no handshake that cycle), go to INJECT and set err_timeout.
  - A handshake in that same cycle wins, and no timeout occurs.
- State INJECT:
  - When the slot is free, load a synthetic beat: tdata=0, tkeep=0, tlast=1, tid/tdest latched, tlast_forced=1.
  - Then go to DROP.
- State DROP:
  - Discard input beats until an input beat with tlast=1 is accepted; that beat is also discarded. Then go to IDLE.
  - No timeout applies in DROP.
- tkeep and tdata pass unmodified, except on injected beats.
- Sticky errors: a set and err_clear in the same cycle leaves the bit set.
- pkt_in_progress is combinational from state.

Test Plan:
- 3-beat packet (tid=2, tdest=5, last beat tkeep=0x0F), out_tready=1 -> identical 3 beats, each 1 cycle later; tlast_forced never high; no errors.
- MAX_PKT_BEATS=4, 6-beat packet with tlast on beat 6 -> 4 output beats, beat 4 with tlast=1 and tlast_forced=1; beats 5-6 dropped with in_tready=1; err_oversize=1; next packet passes normally.
- TIMEOUT_CYCLES=8, 2 beats then tvalid low for 8 cycles -> injected beat (tkeep=0, tlast=1, tlast_forced=1) after beat 2; err_timeout=1; a later 3-beat tail ending in tlast is dropped; state IDLE.
- Packet whose tdest changes from 5 to 7 on beat 2 -> output tdest=5 on all beats; err_id_change=1; err_clear pulse returns it to 0.
- out_tready toggling 1,0,0,1 with continuous input -> no beat lost or duplicated; data stable while stalled; in_tready=0 while the slot is full and stalled.
- aresetn low mid-packet with a held beat -> next cycle out_tvalid=0, pkt_in_progress=0, errors 0; a new packet is accepted immediately.
